// File: rtl/audio_cue_pkg.sv
// Shared definitions for the audio cue scheduler.
// Provides cue ids, FSM state encodings, counter widths, the sample payload
// struct and a modulo-3 cue successor helper.
package audio_cue_pkg;

    localparam int unsigned DUR_W    = 24;
    localparam int unsigned PH_W     = 17;
    localparam int unsigned CUE_W    = 2;
    localparam int unsigned NUM_CUES = 3;
    localparam int unsigned SAMPLE_W = 32;

    typedef enum logic [CUE_W-1:0] {
        CUE_MATCH  = 2'd0,
        CUE_HALT   = 2'd1,
        CUE_SPREAD = 2'd2
    } cue_id_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Stereo sample pushed into the audio_controller write port
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_t;

    // Next cue id in round-robin order (mod 3)
    function automatic logic [CUE_W-1:0] next_cue(input logic [CUE_W-1:0] id);
        return (id >= CUE_W'(NUM_CUES - 1)) ? CUE_W'(0) : CUE_W'(id + CUE_W'(1));
    endfunction

endpackage

// File: rtl/audio_cue_arbiter.sv
// Combinational winner select among pending cues.
// Build option: AUDIO_CUE_RR_EN selects round-robin search starting after
// last_grant; otherwise fixed priority halt > match > spread.
// Ports:
//   pending    in  3  latched cue requests
//   last_grant in  2  most recently granted cue (round-robin only)
//   valid_c    out 1  any cue pending
//   id_c       out 2  winning cue id
module audio_cue_arbiter
    import audio_cue_pkg::*;
(
    input  logic [NUM_CUES-1:0] pending,
    input  logic [CUE_W-1:0]    last_grant,
    output logic                valid_c,
    output logic [CUE_W-1:0]    id_c
);

`ifdef AUDIO_CUE_RR_EN
    logic [CUE_W-1:0] cand;
    logic             found;

    // Walk the three cues starting just after the last grant
    always_comb begin
        valid_c = |pending;
        id_c    = '0;
        found   = 1'b0;
        cand    = next_cue(last_grant);
        for (int i = 0; i < int'(NUM_CUES); i++) begin
            if (!found && pending[cand]) begin
                id_c  = cand;
                found = 1'b1;
            end
            cand = next_cue(cand);
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Fixed priority: halt beats match beats spread
    always_comb begin
        valid_c = |pending;
        id_c    = CUE_MATCH;
        if (pending[CUE_HALT]) begin
            id_c = CUE_HALT;
        end else if (pending[CUE_MATCH]) begin
            id_c = CUE_MATCH;
        end else if (pending[CUE_SPREAD]) begin
            id_c = CUE_SPREAD;
        end
    end
`endif

endmodule

// File: rtl/audio_cue_scheduler.sv
// Shares one square-wave audio path between trade-match, halt and
// spread-alert cues: latches one-cycle requests, arbitrates, plays the tone
// for DURATION cycles, then stays silent for GAP_CYCLES.
// Build option: AUDIO_CUE_RR_EN enables round-robin arbitration.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   cue_req        one-cycle request pulses, bit i = cue i
//   audio_allowed  audio_controller FIFO has room
//   write_out      sample write strobe
//   left_out       left sample, right_out mirrors it
//   busy           high in PLAY or GAP
//   grant_id       cue being played, valid while busy
//   cue_done       one-cycle pulse on PLAY->GAP
module audio_cue_scheduler
    import audio_cue_pkg::*;
#(
    parameter int unsigned       HALF_PERIOD_0 = 25000,
    parameter int unsigned       HALF_PERIOD_1 = 50000,
    parameter int unsigned       HALF_PERIOD_2 = 12500,
    parameter int unsigned       DURATION      = 10000000,
    parameter int unsigned       GAP_CYCLES    = 2500000,
    parameter logic [SAMPLE_W-1:0] AMPL        = 32'h08000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CUES-1:0] cue_req,
    input  logic                audio_allowed,
    output logic                write_out,
    output logic [SAMPLE_W-1:0] left_out,
    output logic [SAMPLE_W-1:0] right_out,
    output logic                busy,
    output logic [CUE_W-1:0]    grant_id,
    output logic                cue_done
);

    state_t              state_q, state_d;
    logic [NUM_CUES-1:0] pending_q, pending_d, grant_clr;
    logic [DUR_W-1:0]    dur_q, dur_d, gap_q, gap_d;
    logic [PH_W-1:0]     ph_q, ph_d, ph_last;
    logic                level_q, level_d;
    logic [CUE_W-1:0]    grant_q, grant_d;
    logic                busy_q, busy_d, done_q, done_d, write_q, write_d;
    sample_t             sample_q, sample_d;
    logic                arb_valid;
    logic [CUE_W-1:0]    arb_id, last_q;

`ifdef AUDIO_CUE_RR_EN
    // Last granted cue seeds the round-robin search
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= CUE_SPREAD;
        end else if (state_q == S_IDLE && arb_valid) begin
            last_q <= arb_id;
        end
    end
`else
    assign last_q = CUE_SPREAD;
`endif

    audio_cue_arbiter u_arbiter (
        .pending    (pending_q),
        .last_grant (last_q),
        .valid_c    (arb_valid),
        .id_c       (arb_id)
    );

    // Half-period terminal count for the cue being played
    always_comb begin
        case (grant_q)
            CUE_HALT:   ph_last = PH_W'(HALF_PERIOD_1 - 1);
            CUE_SPREAD: ph_last = PH_W'(HALF_PERIOD_2 - 1);
            default:    ph_last = PH_W'(HALF_PERIOD_0 - 1);
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        grant_clr = '0;
        dur_d     = dur_q;
        gap_d     = gap_q;
        ph_d      = ph_q;
        level_d   = level_q;
        grant_d   = grant_q;
        done_d    = 1'b0;
        write_d   = 1'b0;
        sample_d  = sample_q;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_clr = NUM_CUES'(1) << arb_id;
                    grant_d   = arb_id;
                    dur_d     = '0;
                    gap_d     = '0;
                    ph_d      = '0;
                    level_d   = 1'b1;
                    state_d   = S_PLAY;
                end
            end
            S_PLAY: begin
                // Duration counts cycles; back-pressure only drops samples
                write_d = audio_allowed;
                if (audio_allowed) begin
                    sample_d.left  = level_q ? AMPL : (SAMPLE_W'(0) - AMPL);
                    sample_d.right = level_q ? AMPL : (SAMPLE_W'(0) - AMPL);
                end
                dur_d = dur_q + DUR_W'(1);
                if (ph_q == ph_last) begin
                    ph_d    = '0;
                    level_d = ~level_q;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
                if (dur_q == DUR_W'(DURATION - 1)) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                gap_d = gap_q + DUR_W'(1);
                if (gap_q == DUR_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        // Same-cycle request for the granted cue survives the clear
        pending_d = (pending_q & ~grant_clr) | cue_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            ph_q      <= '0;
            level_q   <= 1'b1;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            write_q   <= 1'b0;
            sample_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            ph_q      <= ph_d;
            level_q   <= level_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            write_q   <= write_d;
            sample_q  <= sample_d;
        end
    end

    assign write_out = write_q;
    assign left_out  = sample_q.left;
    assign right_out = sample_q.right;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign cue_done  = done_q;

endmodule

// File: tb/tb_audio_cue_scheduler.sv
// Self-checking bench for audio_cue_scheduler with a timeline reference model:
// each granted cue is described by its grant cycle, from which busy, write,
// sample level and cue_done windows follow arithmetically.
module tb_audio_cue_scheduler;

    localparam int unsigned HP0  = 4;
    localparam int unsigned HP1  = 8;
    localparam int unsigned HP2  = 2;
    localparam int unsigned DUR  = 40;
    localparam int unsigned GAP  = 10;
    localparam logic [31:0] AMPL = 32'h08000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cue_req;
    logic        audio_allowed;
    logic        write_out;
    logic [31:0] left_out, right_out;
    logic        busy;
    logic [1:0]  grant_id;
    logic        cue_done;

    always #5 clk = ~clk;

    audio_cue_scheduler #(
        .HALF_PERIOD_0 (HP0),
        .HALF_PERIOD_1 (HP1),
        .HALF_PERIOD_2 (HP2),
        .DURATION      (DUR),
        .GAP_CYCLES    (GAP),
        .AMPL          (AMPL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cue_req       (cue_req),
        .audio_allowed (audio_allowed),
        .write_out     (write_out),
        .left_out      (left_out),
        .right_out     (right_out),
        .busy          (busy),
        .grant_id      (grant_id),
        .cue_done      (cue_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    bit [2:0] m_pend = '0;
    bit       m_active = 1'b0;
    int       m_id = 0;
    int       m_t = 0;
    int       m_last = 2;
    bit       m_prev_allow = 1'b1;
    bit       m_zero_chk = 1'b1;

    // Observed activity for directed checks
    int done_seen   = 0;
    int writes_seen = 0;
    int order[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int hp_of(input int id);
        case (id)
            1:       return int'(HP1);
            2:       return int'(HP2);
            default: return int'(HP0);
        endcase
    endfunction

    function automatic int pick(input bit [2:0] p, input int last);
`ifdef AUDIO_CUE_RR_EN
        for (int i = 1; i <= 3; i++) begin
            if (p[(last + i) % 3]) return (last + i) % 3;
        end
`else
        if (p[1]) return 1;
        if (p[0]) return 0;
        if (p[2]) return 2;
`endif
        return -1;
    endfunction

    // One clock cycle: check outputs, advance model, drive next inputs
    task automatic step(input logic [2:0] req, input bit allow, input bit rst);
        bit          e_busy, e_write, e_done;
        int          k;
        logic [31:0] e_smp;
        @(negedge clk);
        e_busy  = m_active && cyc >= m_t + 1 && cyc <= m_t + int'(DUR + GAP);
        e_write = m_active && cyc >= m_t + 2 && cyc <= m_t + int'(DUR) + 1 && m_prev_allow;
        e_done  = m_active && cyc == m_t + int'(DUR) + 1;
        check_val("busy", 32'(busy), 32'(e_busy));
        check_val("write_out", 32'(write_out), 32'(e_write));
        check_val("cue_done", 32'(cue_done), 32'(e_done));
        if (e_busy) check_val("grant_id", 32'(grant_id), 32'(m_id));
        if (e_write) begin
            k     = cyc - (m_t + 2);
            e_smp = ((k / hp_of(m_id)) % 2 == 0) ? AMPL : (32'(0) - AMPL);
            check_val("left_out", left_out, e_smp);
            check_val("right_out", right_out, e_smp);
        end
        if (m_zero_chk) begin
            check_val("rst_grant_id", 32'(grant_id), 32'(0));
            check_val("rst_left", left_out, 32'(0));
            check_val("rst_right", right_out, 32'(0));
            m_zero_chk = 1'b0;
        end
        if (cue_done === 1'b1) begin
            done_seen++;
            order.push_back(int'(grant_id));
        end
        if (write_out === 1'b1) writes_seen++;

        if (rst) begin
            m_pend     = '0;
            m_active   = 1'b0;
            m_last     = 2;
            m_zero_chk = 1'b1;
        end else begin
            if (m_active && cyc >= m_t + int'(DUR + GAP) + 1) m_active = 1'b0;
            if (!m_active && m_pend != 0) begin
                m_id         = pick(m_pend, m_last);
                m_t          = cyc;
                m_active     = 1'b1;
                m_pend[m_id] = 1'b0;
                m_last       = m_id;
            end
            m_pend = m_pend | req;
        end
        m_prev_allow = allow;

        reset         = rst;
        cue_req       = req;
        audio_allowed = allow;
        cyc++;
    endtask

    int d0, w0;
    int exp_order[3];

    initial begin
        reset         = 1'b1;
        cue_req       = '0;
        audio_allowed = 1'b1;

        // Reset, then long idle
        step(3'b000, 1'b1, 1'b1);
        w0 = writes_seen;
        repeat (100) step(3'b000, 1'b1, 1'b0);
        check_val("idle_writes", 32'(writes_seen - w0), 32'(0));

        // Single match cue
        d0 = done_seen; w0 = writes_seen;
        step(3'b001, 1'b1, 1'b0);
        repeat (60) step(3'b000, 1'b1, 1'b0);
        check_val("single_done", 32'(done_seen - d0), 32'(1));
        check_val("single_writes", 32'(writes_seen - w0), 32'(DUR));

        // All three at once, fresh from reset
        step(3'b000, 1'b1, 1'b1);
        order.delete();
        step(3'b111, 1'b1, 1'b0);
        repeat (180) step(3'b000, 1'b1, 1'b0);
`ifdef AUDIO_CUE_RR_EN
        exp_order = '{0, 1, 2};
`else
        exp_order = '{1, 0, 2};
`endif
        check_val("order_len", 32'(order.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < order.size()) check_val("order", 32'(order[i]), 32'(exp_order[i]));
        end

        // Repeated requests during PLAY merge into one
        d0 = done_seen;
        step(3'b001, 1'b1, 1'b0);
        repeat (5) step(3'b000, 1'b1, 1'b0);
        repeat (3) begin
            step(3'b001, 1'b1, 1'b0);
            repeat (3) step(3'b000, 1'b1, 1'b0);
        end
        repeat (130) step(3'b000, 1'b1, 1'b0);
        check_val("merge_done", 32'(done_seen - d0), 32'(2));

        // Back-pressure toggling drops samples but not duration
        d0 = done_seen; w0 = writes_seen;
        step(3'b001, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) step(3'b000, bit'(i % 2), 1'b0);
        repeat (20) step(3'b000, 1'b1, 1'b0);
        check_val("bp_done", 32'(done_seen - d0), 32'(1));
        check_val("bp_writes", 32'(writes_seen - w0), 32'(DUR / 2));

        // Reset mid-PLAY with spread pending
        step(3'b001, 1'b1, 1'b0);
        repeat (10) step(3'b000, 1'b1, 1'b0);
        step(3'b100, 1'b1, 1'b0);
        repeat (5) step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b1);
        d0 = done_seen; w0 = writes_seen;
        repeat (100) step(3'b000, 1'b1, 1'b0);
        check_val("post_rst_writes", 32'(writes_seen - w0), 32'(0));
        check_val("post_rst_done", 32'(done_seen - d0), 32'(0));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] r;
            r = ($urandom % 20 == 0) ? 3'($urandom % 8) : 3'b000;
            step(r, bit'($urandom % 4 != 0), bit'($urandom % 500 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
